uart_tx_arbiter: RTL

//  Shares one UART transmitter (start/data/busy/done interface, 8N1, 115200 baud at 50 MHz)

---
 rtl/uart_tx_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART transmitter among N_REQ byte requesters,
// with grant locking for multi-byte messages, optional inter-frame gap and done timeout.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | arbitrating; accepts a byte when the transmitter is not busy
// S_SEND    | one cycle after tx_start; clears the timeout counter
// S_WAIT    | waiting for tx_done, aborting after TIMEOUT_CLKS cycles
// S_GAP     | IFG_CLKS idle cycles before the next arbitration
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int TIMEOUT_CLKS = 8192,
  parameter int IFG_CLKS     = 0,
  localparam int IW          = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ-1:0]   req_lock,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  input  logic               tx_busy,
  input  logic               tx_done,
  output logic [IW-1:0]      grant_id,
  output logic               arb_busy,
  output logic               timeout_err
);

  localparam int TW = $clog2(TIMEOUT_CLKS);
  localparam int GW = (IFG_CLKS > 1) ? $clog2(IFG_CLKS) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);
  localparam logic [GW-1:0] GAP_LOAD = (IFG_CLKS > 0) ? GW'(IFG_CLKS - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_GAP} state_t;

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  req_ready_q, req_ready_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [IW-1:0]     grant_id_q, grant_id_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic              arb_busy_q, arb_busy_d;
  logic              timeout_err_q, timeout_err_d;
  logic              lock_q, lock_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [GW-1:0]     gap_q, gap_d;

  logic              win_found;
  logic [IW-1:0]     win_idx;
  logic [IW-1:0]     cand_idx;
  logic              do_accept;
  logic [IW-1:0]     sel_idx;

  // Priority search starting just after the last owner; idle requesters cost no cycles.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand_idx = IW'((int'(ptr_q) + off) % N_REQ);
      if (!win_found && req_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    req_ready_d   = '0;
    tx_start_d    = 1'b0;
    tx_data_d     = tx_data_q;
    grant_id_d    = grant_id_q;
    ptr_d         = ptr_q;
    timeout_err_d = 1'b0;
    lock_d        = lock_q;
    tmo_d         = tmo_q;
    gap_d         = gap_q;
    do_accept     = 1'b0;
    sel_idx       = win_idx;

    case (state_q)
      S_IDLE: begin
        if (!tx_busy) begin
          if (lock_q && req_lock[grant_id_q]) begin
            sel_idx   = grant_id_q;
            do_accept = req_valid[grant_id_q];
          end else begin
            lock_d    = 1'b0;
            do_accept = win_found;
          end
        end
      end
      S_SEND: begin
        state_d = S_WAIT;
        tmo_d   = '0;
      end
      S_WAIT: begin
        tmo_d = tmo_q + TW'(1);
        // A done arriving on the last timeout cycle still counts as success.
        if (tx_done) begin
          lock_d  = req_lock[grant_id_q];
          state_d = (IFG_CLKS > 0) ? S_GAP : S_IDLE;
          gap_d   = GAP_LOAD;
        end else if (tmo_q == TMO_LAST) begin
          timeout_err_d = 1'b1;
          lock_d        = 1'b0;
          state_d       = (IFG_CLKS > 0) ? S_GAP : S_IDLE;
          gap_d         = GAP_LOAD;
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (do_accept) begin
      req_ready_d[sel_idx] = 1'b1;
      tx_start_d           = 1'b1;
      tx_data_d            = req_data[{sel_idx, 3'b000} +: 8];
      grant_id_d           = sel_idx;
      ptr_d                = sel_idx;
      state_d              = S_SEND;
    end

    arb_busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      req_ready_q   <= '0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      grant_id_q    <= '0;
      ptr_q         <= IW'(N_REQ - 1);
      arb_busy_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      lock_q        <= 1'b0;
      tmo_q         <= '0;
      gap_q         <= '0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      grant_id_q    <= grant_id_d;
      ptr_q         <= ptr_d;
      arb_busy_q    <= arb_busy_d;
      timeout_err_q <= timeout_err_d;
      lock_q        <= lock_d;
      tmo_q         <= tmo_d;
      gap_q         <= gap_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_id_q;
  assign arb_busy    = arb_busy_q;
  assign timeout_err = timeout_err_q;

endmodule
